// File: rtl/mac_drain.sv
// mac_drain: sequences a K_LEN-cycle dot product on an external mac stage, then
// requantizes the accumulator with rounding and saturation into a result FIFO.
module mac_drain #(
    parameter int K_LEN      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               start_ready,
    input  logic [3:0]         shift,
    output logic               operand_en,
    output logic               macc_clear,
    input  logic signed [18:0] acc_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [7:0]  out_data,
    output logic               out_sat
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]  K_LAST  = 8'(K_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, CAPTURE} state_t;

    state_t             state, state_nx;
    logic [7:0]         cnt;
    logic [3:0]         shift_q;
    logic               accept, push, pop;

    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic signed [7:0]  mem_data [FIFO_DEPTH];
    logic               mem_sat  [FIFO_DEPTH];

    logic signed [19:0] acc_ext, rnd, rq;
    logic signed [7:0]  rq_data;
    logic               rq_sat;

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx    = state;
        start_ready = 1'b0;
        operand_en  = 1'b0;
        macc_clear  = 1'b0;
        case (state)
            IDLE: begin
                start_ready = (count < DEPTH_C);
                if (start && start_ready) state_nx = ACCUM;
            end
            ACCUM: begin
                operand_en = 1'b1;
                macc_clear = (cnt == 8'd0);
                if (cnt == K_LAST) state_nx = CAPTURE;
            end
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign accept = start && start_ready;
    assign push   = (state == CAPTURE);
    assign pop    = out_valid && out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            shift_q <= 4'd0;
        end else begin
            state <= state_nx;
            if (accept) shift_q <= shift;
            if (state == ACCUM) cnt <= (cnt == K_LAST) ? 8'd0 : cnt + 8'd1;
            else                cnt <= 8'd0;
        end
    end

    // Round half up, then arithmetic shift; 20 bits hold acc_in plus the rounding term.
    always_comb begin
        acc_ext = {acc_in[18], acc_in};
        rnd     = (shift_q == 4'd0) ? 20'sd0 : (20'sd1 <<< (shift_q - 4'd1));
        rq      = (acc_ext + rnd) >>> shift_q;
        rq_sat  = 1'b0;
        rq_data = rq[7:0];
        if (rq > 20'sd127) begin
            rq_data = 8'sd127;
            rq_sat  = 1'b1;
        end else if (rq < -20'sd128) begin
            rq_data = -8'sd128;
            rq_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; out_valid gates it, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= rq_data;
            mem_sat[wr_ptr]  <= rq_sat;
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem_data[rd_ptr] : 8'sd0;
    assign out_sat   = out_valid ? mem_sat[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_mac_drain.sv
// Bench for mac_drain: behavioural mac stage feeds acc_in, a scoreboard queue
// holds expected requantized results, a negedge monitor pops and compares.
module tb_mac_drain;
    localparam int K_LEN      = 8;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst, start, start_ready, operand_en, macc_clear;
    logic [3:0]         shift;
    logic signed [18:0] acc_in;
    logic               out_valid, out_ready, out_sat;
    logic signed [7:0]  out_data;

    logic rand_mode = 1'b0, rdy_rand = 1'b0, rdy_ctl = 1'b0;
    assign out_ready = rand_mode ? rdy_rand : rdy_ctl;

    always #5 clk = ~clk;

    mac_drain #(.K_LEN(K_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .shift(shift), .operand_en(operand_en), .macc_clear(macc_clear),
        .acc_in(acc_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    typedef struct { int a; int b; } op_t;
    typedef struct { logic signed [7:0] d; logic s; } exp_t;

    int     errors = 0, checks = 0;
    op_t    opq[$];
    exp_t   expq[$];
    int     job_a[K_LEN], job_b[K_LEN];
    longint acc_q = 0;
    op_t    mac_p;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference requantizer: wrap to 19 bits, add half-LSB, floor-divide, clamp.
    function automatic void ref_requant(input longint sum, input int s,
                                        output logic signed [7:0] d, output logic sat);
        longint v, den, n, q;
        v = sum & 64'h7FFFF;
        if (v >= 262144) v -= 524288;
        den = longint'(1) << s;
        n   = v + ((s > 0) ? den / 2 : 0);
        q   = n / den;
        if ((n % den) != 0 && n < 0) q -= 1;
        sat = 1'b0;
        if (q > 127)       begin d = 8'sd127;  sat = 1'b1; end
        else if (q < -128) begin d = -8'sd128; sat = 1'b1; end
        else               d = 8'(q);
    endfunction

    // Behavioural mac stage: consumes one operand pair per operand_en cycle.
    always @(posedge clk) begin
        if (rst) opq.delete();
        else if (operand_en) begin
            check("operands_available", int'(opq.size() > 0), 1);
            if (opq.size() > 0) begin
                mac_p = opq.pop_front();
                acc_q <= (macc_clear ? 64'sd0 : acc_q) + longint'(mac_p.a) * mac_p.b;
            end
        end
    end
    assign acc_in = acc_q[18:0];

    always @(posedge clk) begin
        #1;
        rdy_rand = ($urandom_range(0, 9) < 7);
    end

    // Scoreboard monitor plus head-stability check while stalled.
    logic              hold_v = 1'b0, hold_s;
    logic signed [7:0] hold_d;
    exp_t              mon_e;
    always @(negedge clk) begin
        if (rst) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_d);
                check("hold_sat", out_sat, hold_s);
            end
            hold_v = 1'b0;
            if (out_valid && out_ready) begin
                check("result_expected", int'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    mon_e = expq.pop_front();
                    check("out_data", out_data, mon_e.d);
                    check("out_sat", out_sat, mon_e.s);
                end
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_d = out_data;
                hold_s = out_sat;
            end
        end
    end

    // Every operand_en burst lasts K_LEN cycles with macc_clear only on its first.
    int run_len = 0;
    always @(negedge clk) begin
        if (rst) run_len = 0;
        else if (operand_en) begin
            check("clear_first_only", macc_clear, int'(run_len == 0));
            run_len++;
        end else begin
            check("clear_idle", macc_clear, 0);
            if (run_len > 0) check("accum_len", run_len, K_LEN);
            run_len = 0;
        end
    end

    task automatic set_const(input int a, input int b);
        for (int k = 0; k < K_LEN; k++) begin job_a[k] = a; job_b[k] = b; end
    endtask

    task automatic set_single(input int v);
        for (int k = 0; k < K_LEN; k++) begin
            job_a[k] = (k == 0) ? v : 0;
            job_b[k] = (k == 0) ? 1 : 0;
        end
    endtask

    task automatic set_rand();
        int mag;
        case ($urandom_range(0, 3))
            0: mag = 3;
            1: mag = 20;
            2: mag = 127;
            default: mag = 400;
        endcase
        for (int k = 0; k < K_LEN; k++) begin
            job_a[k] = int'($urandom_range(0, 2 * mag)) - mag;
            job_b[k] = int'($urandom_range(0, 2 * mag)) - mag;
        end
    endtask

    // Holds start until accepted; returns just after the acceptance edge.
    task automatic issue(input logic [3:0] s, input bit keep, input bit fixed,
                         input logic signed [7:0] fd, input logic fs);
        exp_t   e;
        op_t    p;
        longint sum;
        int     n;
        @(posedge clk); #1;
        start = 1'b1;
        shift = s;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 500) begin @(negedge clk); n++; end
        check("start_accepted", start_ready, 1);
        if (!start_ready) begin start = 1'b0; return; end
        sum = 0;
        for (int k = 0; k < K_LEN; k++) begin
            p.a = job_a[k];
            p.b = job_b[k];
            opq.push_back(p);
            sum += longint'(job_a[k]) * job_b[k];
        end
        if (keep) begin
            if (fixed) begin e.d = fd; e.s = fs; end
            else ref_requant(sum, int'(s), e.d, e.s);
            expq.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        shift = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() > 0 && n < 3000) begin @(posedge clk); n++; end
        check("drained", expq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int en_cnt, clr_cnt, clr_at, first_v, seen;
        rst = 1'b1; start = 1'b0; shift = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_start_ready", start_ready, 1);
        check("rst_operand_en", operand_en, 0);
        check("rst_macc_clear", macc_clear, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);

        // 3*5 over 8 cycles, shift 0 -> 120; a stray start mid-ACCUM must be ignored.
        rdy_ctl = 1'b1;
        set_const(3, 5);
        issue(4'd0, 1'b1, 1'b1, 8'sd120, 1'b0);
        en_cnt = 0; clr_cnt = 0; clr_at = 0; first_v = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            en_cnt += int'(operand_en);
            if (macc_clear) begin clr_cnt++; clr_at = i; end
            if (out_valid && first_v == 0) first_v = i;
            if (i == 10) check("t10_data", out_data, 120);
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
        end
        check("en_cycles", en_cnt, K_LEN);
        check("clear_cycles", clr_cnt, 1);
        check("clear_at", clr_at, 1);
        check("first_valid_at", first_v, K_LEN + 2);
        drain();

        // Rounding and saturation corners.
        set_single(37);    issue(4'd2, 1'b1, 1'b1, 8'sd9, 1'b0);
        set_single(-37);   issue(4'd2, 1'b1, 1'b1, -8'sd9, 1'b0);
        set_single(-300);  issue(4'd1, 1'b1, 1'b1, -8'sd128, 1'b1);
        set_single(1000);  issue(4'd0, 1'b1, 1'b1, 8'sd127, 1'b1);
        set_single(-1);    issue(4'd1, 1'b1, 1'b0, 8'sd0, 1'b0);
        set_single(262143); issue(4'd15, 1'b1, 1'b0, 8'sd0, 1'b0);
        drain();

        // Reset at ACCUM counter 3 aborts with no result.
        set_const(7, 9);
        issue(4'd0, 1'b0, 1'b0, 8'sd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_operand_en", operand_en, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_start_ready", start_ready, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); seen += int'(out_valid); end
        check("abort_no_result", seen, 0);
        check("abort_ops_flushed", opq.size(), 0);

        // Fill the FIFO, then one pop re-opens start_ready.
        rdy_ctl = 1'b0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            set_rand();
            issue(4'($urandom_range(0, 8)), 1'b1, 1'b0, 8'sd0, 1'b0);
        end
        repeat (K_LEN + 1) @(posedge clk);
        @(negedge clk);
        check("full_start_ready", start_ready, 0);
        check("full_out_valid", out_valid, 1);
        @(posedge clk); #1 rdy_ctl = 1'b1;
        @(posedge clk); #1 rdy_ctl = 1'b0;
        @(negedge clk);
        check("after_pop_start_ready", start_ready, 1);
        rdy_ctl = 1'b1;
        drain();

        // Pop coincides with the CAPTURE push at occupancy 3.
        rdy_ctl = 1'b0;
        for (int j = 0; j < 4; j++) begin
            set_rand();
            issue(4'($urandom_range(0, 8)), 1'b1, 1'b0, 8'sd0, 1'b0);
        end
        repeat (K_LEN) @(posedge clk);
        #1 rdy_ctl = 1'b1;
        @(posedge clk); #1 rdy_ctl = 1'b0;
        @(negedge clk);
        check("push_pop_start_ready", start_ready, 1);
        check("push_pop_out_valid", out_valid, 1);
        rdy_ctl = 1'b1;
        drain();

        // Randomized jobs with random consumer back-pressure.
        rand_mode = 1'b1;
        for (int j = 0; j < 40; j++) begin
            set_rand();
            issue(4'($urandom), 1'b1, 1'b0, 8'sd0, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain();
        rand_mode = 1'b0;
        check("ops_consumed", opq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
